// File: rtl/cart_bus_if.sv
// Signal bundle between the cartridge bus arbiter, its two requesters and the cartridge pins.
// Handshakes: gb_req is a level held until the one-cycle gb_ack; a host transfer is accepted in
// the cycle where host_valid && host_ready, and completes with a one-cycle host_done pulse.
interface cart_bus_if;
  logic        gb_req;
  logic        gb_write;
  logic [15:0] gb_addr;
  logic [7:0]  gb_wdata;
  logic        gb_cs;
  logic        gb_ack;
  logic [7:0]  gb_rdata;

  logic        host_valid;
  logic        host_ready;
  logic        host_write;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_cs;
  logic        host_done;
  logic [7:0]  host_rdata;

  logic [15:0] cart_A;
  logic [7:0]  cart_D_out;
  logic        cart_D_oe;
  logic [7:0]  cart_D_in;
  logic        cart_nRD;
  logic        cart_nWR;
  logic        cart_nCS;
  logic        busy;
  logic [1:0]  dbg_state;

  modport slave (
    input  gb_req, gb_write, gb_addr, gb_wdata, gb_cs,
    input  host_valid, host_write, host_addr, host_wdata, host_cs,
    input  cart_D_in,
    output gb_ack, gb_rdata, host_ready, host_done, host_rdata,
    output cart_A, cart_D_out, cart_D_oe, cart_nRD, cart_nWR, cart_nCS, busy, dbg_state
  );

  modport master (
    output gb_req, gb_write, gb_addr, gb_wdata, gb_cs,
    output host_valid, host_write, host_addr, host_wdata, host_cs,
    output cart_D_in,
    input  gb_ack, gb_rdata, host_ready, host_done, host_rdata,
    input  cart_A, cart_D_out, cart_D_oe, cart_nRD, cart_nWR, cart_nCS, busy, dbg_state
  );
endinterface

// File: rtl/cart_bus_arbiter.sv
// Game Boy cartridge bus sequencer shared between the core (priority) and the host port,
// with a fixed SETUP/STROBE/HOLD access shape and a streak counter bounding host starvation.
module cart_bus_arbiter #(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1,
  parameter int HOST_MAX_WAIT = 8
) (
  input logic     clk,
  input logic     reset_n,
  cart_bus_if.slave bus
);
  localparam int MAXC = (SETUP_CYCLES > STROBE_CYCLES)
                      ? ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES)
                      : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int SW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, STROBE = 2'd2, HOLD = 2'd3} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          owner_q, owner_d;  // 0 = Game Boy, 1 = host
  logic          wr_q, wr_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          cs_q, cs_d;
  logic [7:0]    rd_buf_q, rd_buf_d;

  logic          gb_ack_q, gb_ack_d;
  logic          host_done_q, host_done_d;
  logic [7:0]    gb_rdata_q, gb_rdata_d;
  logic [7:0]    host_rdata_q, host_rdata_d;
  logic [15:0]   cart_A_q, cart_A_d;
  logic [7:0]    cart_D_out_q, cart_D_out_d;
  logic          cart_D_oe_q, cart_D_oe_d;
  logic          cart_nRD_q, cart_nRD_d;
  logic          cart_nWR_q, cart_nWR_d;
  logic          cart_nCS_q, cart_nCS_d;
  logic          busy_q, busy_d;

  logic can_grant, host_win, gb_grant, host_grant, done, in_acc;

  // No grant in the ack/done cycle, so the bus always idles one cycle between accesses.
  assign can_grant  = (state_q == IDLE) && !gb_ack_q && !host_done_q;
  assign host_win   = bus.host_valid && (!bus.gb_req || (streak_q == STREAK_MAX));
  assign host_grant = can_grant && host_win;
  assign gb_grant   = can_grant && bus.gb_req && !host_win;
  assign done       = (state_q == HOLD) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cs_d    = cs_q;
    case (state_q)
      IDLE: begin
        if (gb_grant) begin
          state_d = SETUP;  cnt_d = SETUP_LD;  owner_d = 1'b0;
          wr_d = bus.gb_write;  addr_d = bus.gb_addr;  wdata_d = bus.gb_wdata;  cs_d = bus.gb_cs;
        end else if (host_grant) begin
          state_d = SETUP;  cnt_d = SETUP_LD;  owner_d = 1'b1;
          wr_d = bus.host_write;  addr_d = bus.host_addr;  wdata_d = bus.host_wdata;  cs_d = bus.host_cs;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin state_d = STROBE; cnt_d = STROBE_LD; end
        else cnt_d = cnt_q - CW'(1);
      end
      STROBE: begin
        if (cnt_q == '0) begin state_d = HOLD; cnt_d = HOLD_LD; end
        else cnt_d = cnt_q - CW'(1);
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    streak_d = streak_q;
    if (!bus.host_valid || host_grant) streak_d = '0;
    else if (gb_grant && (streak_q != STREAK_MAX)) streak_d = streak_q + SW'(1);

    rd_buf_d     = ((state_q == STROBE) && (cnt_q == '0) && !wr_q) ? bus.cart_D_in : rd_buf_q;
    gb_ack_d     = done && !owner_q;
    host_done_d  = done && owner_q;
    gb_rdata_d   = (done && !owner_q && !wr_q) ? rd_buf_q : gb_rdata_q;
    host_rdata_d = (done && owner_q && !wr_q) ? rd_buf_q : host_rdata_q;

    // Pins are registered from the next state so they change exactly on phase boundaries.
    in_acc       = (state_d != IDLE);
    cart_A_d     = in_acc ? addr_d : cart_A_q;
    cart_D_out_d = in_acc ? wdata_d : cart_D_out_q;
    cart_D_oe_d  = in_acc && wr_d;
    cart_nCS_d   = in_acc ? cs_d : 1'b1;  // cs = 1 selects ROM, which keeps nCS high
    cart_nRD_d   = !(((state_d == SETUP) || (state_d == STROBE)) && !wr_d);
    cart_nWR_d   = !((state_d == STROBE) && wr_d);
    busy_d       = in_acc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      streak_q     <= '0;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cs_q         <= 1'b0;
      rd_buf_q     <= '0;
      gb_ack_q     <= 1'b0;
      host_done_q  <= 1'b0;
      gb_rdata_q   <= '0;
      host_rdata_q <= '0;
      cart_A_q     <= '0;
      cart_D_out_q <= '0;
      cart_D_oe_q  <= 1'b0;
      cart_nRD_q   <= 1'b1;
      cart_nWR_q   <= 1'b1;
      cart_nCS_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cs_q         <= cs_d;
      rd_buf_q     <= rd_buf_d;
      gb_ack_q     <= gb_ack_d;
      host_done_q  <= host_done_d;
      gb_rdata_q   <= gb_rdata_d;
      host_rdata_q <= host_rdata_d;
      cart_A_q     <= cart_A_d;
      cart_D_out_q <= cart_D_out_d;
      cart_D_oe_q  <= cart_D_oe_d;
      cart_nRD_q   <= cart_nRD_d;
      cart_nWR_q   <= cart_nWR_d;
      cart_nCS_q   <= cart_nCS_d;
      busy_q       <= busy_d;
    end
  end

  // host_ready is the grant itself, so it must be combinational to pulse in the grant cycle.
  assign bus.host_ready = host_grant && reset_n;
  assign bus.gb_ack     = gb_ack_q;
  assign bus.host_done  = host_done_q;
  assign bus.gb_rdata   = gb_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.cart_A     = cart_A_q;
  assign bus.cart_D_out = cart_D_out_q;
  assign bus.cart_D_oe  = cart_D_oe_q;
  assign bus.cart_nRD   = cart_nRD_q;
  assign bus.cart_nWR   = cart_nWR_q;
  assign bus.cart_nCS   = cart_nCS_q;
  assign bus.busy       = busy_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Directed bench for cart_bus_arbiter: default timing on dut_a, 1/1/1 timing on dut_b.
module tb_cart_bus_arbiter;
  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   host_ready_cnt;
  logic prev_ack;
  logic [0:0] exp_q[$];
  logic [0:0] e;

  cart_bus_if bus_a();
  cart_bus_if bus_b();

  cart_bus_arbiter dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  cart_bus_arbiter #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1), .HOST_MAX_WAIT(8))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  // Cartridge model: 0x0147 holds 0x13, everything else is addr_lo ^ addr_hi ^ 0xA5.
  function automatic logic [7:0] cart_model(input logic [15:0] a);
    if (a == 16'h0147) return 8'h13;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  always_comb bus_a.cart_D_in = cart_model(bus_a.cart_A);
  always_comb bus_b.cart_D_in = cart_model(bus_b.cart_A);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_a.gb_req = 0; bus_a.gb_write = 0; bus_a.gb_addr = '0; bus_a.gb_wdata = '0; bus_a.gb_cs = 1;
    bus_a.host_valid = 0; bus_a.host_write = 0; bus_a.host_addr = '0; bus_a.host_wdata = '0; bus_a.host_cs = 1;
    bus_b.gb_req = 0; bus_b.gb_write = 0; bus_b.gb_addr = '0; bus_b.gb_wdata = '0; bus_b.gb_cs = 1;
    bus_b.host_valid = 0; bus_b.host_write = 0; bus_b.host_addr = '0; bus_b.host_wdata = '0; bus_b.host_cs = 1;
  endtask

  initial begin
    checks = 0; errors = 0; host_ready_cnt = 0; prev_ack = 0;
    idle_inputs();
    reset_n = 0;
    bus_a.host_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cart_A", bus_a.cart_A, 0);
    chk("rst_D_out", bus_a.cart_D_out, 0);
    chk("rst_D_oe", bus_a.cart_D_oe, 0);
    chk("rst_nRD", bus_a.cart_nRD, 1);
    chk("rst_nWR", bus_a.cart_nWR, 1);
    chk("rst_nCS", bus_a.cart_nCS, 1);
    chk("rst_gb_ack", bus_a.gb_ack, 0);
    chk("rst_host_ready", bus_a.host_ready, 0);
    chk("rst_host_done", bus_a.host_done, 0);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_gb_rdata", bus_a.gb_rdata, 0);
    chk("rst_host_rdata", bus_a.host_rdata, 0);
    chk("rst_state", bus_a.dbg_state, 0);
    bus_a.host_valid = 0;
    reset_n = 1;
    cyc();

    // GB read 0x0147 from ROM
    bus_a.gb_req = 1; bus_a.gb_write = 0; bus_a.gb_addr = 16'h0147; bus_a.gb_cs = 1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("t1_nRD", bus_a.cart_nRD, (k <= 6) ? 0 : 1);
      chk("t1_nWR", bus_a.cart_nWR, 1);
      chk("t1_nCS", bus_a.cart_nCS, 1);
      chk("t1_busy", bus_a.busy, (k <= 7) ? 1 : 0);
      chk("t1_gb_ack", bus_a.gb_ack, (k == 8) ? 1 : 0);
      if (k == 3) chk("t1_cart_A", bus_a.cart_A, 16'h0147);
      if (k == 8) begin
        chk("t1_gb_rdata", bus_a.gb_rdata, 8'h13);
        bus_a.gb_req = 0;
      end
    end

    // GB write 0x5A to RAM 0xA000
    cyc();
    bus_a.gb_req = 1; bus_a.gb_write = 1; bus_a.gb_addr = 16'hA000; bus_a.gb_wdata = 8'h5A; bus_a.gb_cs = 0;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("t2_nCS", bus_a.cart_nCS, (k <= 7) ? 0 : 1);
      chk("t2_nWR", bus_a.cart_nWR, (k >= 3 && k <= 6) ? 0 : 1);
      chk("t2_D_oe", bus_a.cart_D_oe, (k <= 7) ? 1 : 0);
      chk("t2_nRD", bus_a.cart_nRD, 1);
      chk("t2_gb_ack", bus_a.gb_ack, (k == 8) ? 1 : 0);
      if (k == 4) begin
        chk("t2_cart_A", bus_a.cart_A, 16'hA000);
        chk("t2_D_out", bus_a.cart_D_out, 8'h5A);
      end
      if (k == 8) begin
        chk("t2_gb_rdata_kept", bus_a.gb_rdata, 8'h13);
        chk("t2_cart_A_kept", bus_a.cart_A, 16'hA000);
        bus_a.gb_req = 0;
      end
    end

    // Host read 0x0100 while the core is idle
    cyc();
    bus_a.host_valid = 1; bus_a.host_write = 0; bus_a.host_addr = 16'h0100; bus_a.host_cs = 1;
    #1;
    chk("t3_host_ready_grant", bus_a.host_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1) bus_a.host_valid = 0;
      #1;
      chk("t3_host_ready", bus_a.host_ready, 0);
      chk("t3_gb_ack", bus_a.gb_ack, 0);
      chk("t3_host_done", bus_a.host_done, (k == 8) ? 1 : 0);
      chk("t3_nRD", bus_a.cart_nRD, (k <= 6) ? 0 : 1);
      if (k == 8) begin
        chk("t3_host_rdata", bus_a.host_rdata, 8'hA4);
        chk("t3_gb_rdata_kept", bus_a.gb_rdata, 8'h13);
      end
    end

    // Both requesters held: 8 GB accesses, 1 host access, repeated twice
    cyc();
    bus_a.gb_req = 1; bus_a.gb_write = 0; bus_a.gb_addr = 16'h0150; bus_a.gb_cs = 1;
    bus_a.host_valid = 1; bus_a.host_write = 0; bus_a.host_addr = 16'h0100; bus_a.host_cs = 1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back(1'b0);
      exp_q.push_back(1'b1);
    end
    prev_ack = 0;
    for (int k = 0; k <= 161; k++) begin
      if (k > 0) cyc();
      #1;
      if (bus_a.host_ready) host_ready_cnt++;
      if (prev_ack) chk("t4_turn_busy", bus_a.busy, 0);
      prev_ack = bus_a.gb_ack | bus_a.host_done;
      if (prev_ack) begin
        chk("t4_turn_ready", bus_a.host_ready, 0);
        if (exp_q.size() == 0) chk("t4_extra_completion", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("t4_owner", {31'd0, bus_a.host_done}, {31'd0, e});
        end
      end
      if (k == 161) begin
        bus_a.gb_req = 0;
        bus_a.host_valid = 0;
      end
    end
    chk("t4_missing_completions", exp_q.size(), 0);
    chk("t4_host_grants", host_ready_cnt, 2);

    // Reset in the middle of a write strobe
    cyc();
    bus_a.gb_req = 1; bus_a.gb_write = 1; bus_a.gb_addr = 16'hA001; bus_a.gb_wdata = 8'h77; bus_a.gb_cs = 0;
    for (int k = 1; k <= 4; k++) cyc();
    chk("t5_nWR_strobe", bus_a.cart_nWR, 0);
    chk("t5_D_oe_strobe", bus_a.cart_D_oe, 1);
    #1;
    reset_n = 0;
    bus_a.gb_req = 0;
    #1;
    chk("t5_rst_nWR", bus_a.cart_nWR, 1);
    chk("t5_rst_D_oe", bus_a.cart_D_oe, 0);
    chk("t5_rst_busy", bus_a.busy, 0);
    chk("t5_rst_nCS", bus_a.cart_nCS, 1);
    chk("t5_rst_state", bus_a.dbg_state, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk("t5_no_ack", bus_a.gb_ack, 0);
    end
    chk("t5_gb_rdata_reset", bus_a.gb_rdata, 0);
    bus_a.gb_req = 1; bus_a.gb_write = 0; bus_a.gb_addr = 16'h0147; bus_a.gb_cs = 1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("t5_after_ack", bus_a.gb_ack, (k == 8) ? 1 : 0);
      if (k == 8) begin
        chk("t5_after_rdata", bus_a.gb_rdata, 8'h13);
        bus_a.gb_req = 0;
      end
    end

    // 1/1/1 timing: back-to-back GB reads 5 cycles apart
    cyc();
    bus_b.gb_req = 1; bus_b.gb_write = 0; bus_b.gb_addr = 16'h0147; bus_b.gb_cs = 1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      chk("t6_gb_ack", bus_b.gb_ack, (k == 4 || k == 9) ? 1 : 0);
      chk("t6_nRD", bus_b.cart_nRD, (k == 1 || k == 2 || k == 6 || k == 7) ? 0 : 1);
      chk("t6_busy", bus_b.busy, ((k >= 1 && k <= 3) || (k >= 6 && k <= 8)) ? 1 : 0);
      if (k == 4 || k == 9) chk("t6_gb_rdata", bus_b.gb_rdata, 8'h13);
      if (k == 9) bus_b.gb_req = 0;
    end
    cyc();
    cyc();
    chk("t6_idle_busy", bus_b.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
